// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   PC_W / INSTR_W : byte-address and instruction widths
//   PC_INC         : fetch stride in bytes (one 32-bit word)
//   fsm_t          : control FSM encoding
//   fetch_pair_t   : {pc, instruction} entry held in the fetch queue
//   inflight_t     : tracker for the single outstanding memory read
package instr_fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 10'd4;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fsm_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pair_t;

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
    logic            epoch;
  } inflight_t;

  // Fetch addresses are word aligned; low byte-offset bits are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with a single-cycle flush.
//   clk, rst  : clock, async active-high reset
//   flush     : empties the queue and rewinds both pointers (wins over push/pop)
//   push/wdata: write one entry at the tail
//   pop       : retire the head entry (caller guarantees non-empty)
//   rdata     : current head entry
//   count     : number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter  int W     = 42,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word reads to instruction memory,
// queues returned {pc, instruction} pairs and hands them to decode.
//   clk, rst             : clock, async active-high reset
//   imem_req/imem_addr   : one-word read request, addr = fetch PC
//   imem_rvalid/rdata    : read data, exactly one cycle after the request
//   redirect/redirect_pc : branch/jump restart pulse and new target
//   instruction/PC       : head pair of the fetch queue
//   out_valid/out_ready  : decode handshake
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 10'h000,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    PC,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fsm_t            state;
  logic [PC_W-1:0] fpc;
  logic            epoch;
  inflight_t       infl;

  logic [CW-1:0] qcount, occ;
  logic          run, pop, push, flush;
  fetch_pair_t   head, tail;

  assign run       = (state == ST_RUN);
  assign out_valid = (qcount != '0);
  assign pop       = out_valid & out_ready;

  // Occupancy counts the entry being popped this cycle as already gone, so
  // a full-rate stream keeps one request in flight alongside one queued pair.
  // The slot is still guaranteed: the response lands no earlier than next
  // cycle, when that pop has retired.
  assign occ       = qcount - CW'(pop) + CW'(infl.vld);
  assign imem_req  = run & ~redirect & (occ < CW'(QDEPTH));
  assign imem_addr = fpc;

  assign flush = run & redirect;
  // A response arriving with a redirect belongs to the old stream by definition.
  assign push  = run & ~redirect & imem_rvalid & infl.vld & (infl.epoch == epoch);
  assign tail  = '{pc: infl.pc, instr: imem_rdata};

  assign instruction = head.instr;
  assign PC          = head.pc;

  fetch_queue #(
    .W     ($bits(fetch_pair_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (tail),
    .pop   (pop),
    .rdata (head),
    .count (qcount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      fpc   <= RESET_PC;
      epoch <= 1'b0;
      infl  <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_RUN;
          infl.vld <= 1'b0;
        end
        ST_RUN: begin
          if (redirect) begin
            fpc   <= align_pc(redirect_pc);
            epoch <= ~epoch;
          end else if (imem_req) begin
            fpc <= fpc + PC_INC;
          end
          infl <= '{vld: imem_req, pc: fpc, epoch: epoch};
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [9:0] RPC = 10'h000;

  logic        clk, rst;
  logic        imem_req, imem_rvalid, redirect, out_valid, out_ready;
  logic [9:0]  imem_addr, redirect_pc, PC;
  logic [31:0] imem_rdata, instruction;

  instr_fetch #(.RESET_PC(RPC), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instruction(instruction), .PC(PC),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [9:0] pc);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_pc"}, PC, pc);
  endtask

  // Memory contents: every word is tagged with its own address.
  function automatic logic [31:0] word_of(input logic [9:0] a);
    return {12'hC0D, a ^ 10'h155, a};
  endfunction

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];

  // Memory model: answers each request exactly one cycle later.
  logic [9:0] resp_addr;
  initial begin
    logic       nreq;
    logic [9:0] naddr;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    resp_addr   = '0;
    forever begin
      @(negedge clk);
      nreq  = imem_req && !rst;
      naddr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = nreq;
      resp_addr   = naddr;
      imem_rdata  = nreq ? word_of(naddr) : $urandom;
    end
  end

  // Scoreboard push: a returned word joins the expected stream unless a
  // redirect or reset in that cycle kills it; redirect/reset drop everything
  // not yet delivered.
  initial forever begin
    @(negedge clk);
    if (rst || redirect) exp_q.delete();
    else if (imem_rvalid) exp_q.push_back('{pc: resp_addr, ins: word_of(resp_addr)});
  end

  // Monitor: pops the scoreboard on every accepted pair; checks hold stability.
  initial begin
    logic        prev_hold;
    logic [41:0] prev_pair;
    exp_t        e;
    prev_hold = 1'b0;
    prev_pair = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", out_valid, 1'b0);
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_pair", {PC, instruction}, prev_pair);
        end
        if (out_valid && out_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: actual pc=%0h required=none", PC);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", PC, e.pc);
            chk("out_instr", instruction, e.ins);
          end
        end
        prev_hold = out_valid && !out_ready && !redirect;
        prev_pair = {PC, instruction};
      end
    end
  end

  // Fetch-address model: sequential words from reset PC or redirect target.
  initial begin
    logic [9:0] exp_fetch;
    exp_fetch = RPC;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_fetch = RPC;
        chk("rst_no_req", imem_req, 1'b0);
      end else if (redirect) begin
        chk("redirect_no_req", imem_req, 1'b0);
        exp_fetch = {redirect_pc[9:2], 2'b00};
      end else if (imem_req) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 10'd4;
      end
    end
  end

  // Stimulus
  initial begin
    int quiet, rst_hold;
    logic prev_redirect;
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req", imem_req, 1'b0);
    chk("reset_addr", imem_addr, RPC);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_instr", instruction, 32'h0);
    chk("reset_pc", PC, 10'h0);

    // Release: RESET state for one cycle, then fill at full rate.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("reset_state_req", imem_req, 1'b0);
    @(negedge clk);
    chk("run_first_req", imem_req, 1'b1);
    chk("run_first_addr", imem_addr, RPC);
    chk("run_fill_valid0", out_valid, 1'b0);
    @(negedge clk); chk("run_fill_valid1", out_valid, 1'b0);
    @(negedge clk); expect_out("stream0", RPC);
    @(negedge clk); expect_out("stream1", RPC + 10'd4);
    @(negedge clk); expect_out("stream2", RPC + 10'd8);

    // Backpressure: queue fills, requests stop.
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_req", imem_req, 1'b0);
    chk("stall_valid", out_valid, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Redirect with a full queue; target low bits ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 10'h101;
    @(negedge clk);
    @(posedge clk); #1 redirect = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 10'h100);
    chk("redir_flush", out_valid, 1'b0);
    @(negedge clk); chk("redir_fill", out_valid, 1'b0);
    @(negedge clk); expect_out("redir_out", 10'h100);
    repeat (3) @(negedge clk);

    // Address wrap.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 10'h3F8;
    @(negedge clk);
    @(posedge clk); #1 redirect = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("wrap0", 10'h3F8);
    @(negedge clk); expect_out("wrap1", 10'h3FC);
    @(negedge clk); expect_out("wrap2", 10'h000);
    @(negedge clk); expect_out("wrap3", 10'h004);

    // Redirect colliding with a handshake and a returning response.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 10'h2A4;
    @(negedge clk);
    chk("collide_pre_valid", out_valid, 1'b1);
    chk("collide_pre_rvalid", imem_rvalid, 1'b1);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk); chk("collide_valid1", out_valid, 1'b0);
    @(negedge clk); chk("collide_valid2", out_valid, 1'b0);
    @(negedge clk); expect_out("collide_out", 10'h2A4);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-stream while a response is on the bus.
    @(posedge clk); #3;
    chk("arst_pre_rvalid", imem_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_req", imem_req, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("arst_reset_state", imem_req, 1'b0);
    @(negedge clk); chk("arst_restart_addr", imem_addr, RPC);
    chk("arst_restart_req", imem_req, 1'b1);
    @(negedge clk);
    @(negedge clk); expect_out("arst_out", RPC);

    // Randomized traffic: backpressure, redirects and occasional resets.
    quiet = 0; rst_hold = 0; prev_redirect = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      if (rst) begin
        if (rst_hold == 0) begin rst = 1'b0; quiet = 2; end
        else rst_hold--;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; rst_hold = 1;
      end else if (quiet > 0) begin
        quiet--;
      end else if ($urandom_range(0, 15) == 0 && !prev_redirect) begin
        redirect    = 1'b1;
        redirect_pc = 10'($urandom);
      end
      out_ready     = ($urandom_range(0, 3) != 0);
      prev_redirect = redirect;
    end
    @(posedge clk); #1 rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
